axis_packet_arbiter: RTL and testbench



---
 rtl/axis_packet_arbiter_if.sv | 14 +
 rtl/axis_packet_arbiter.sv | 129 ++++++++++++
 tb/tb_axis_packet_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_arbiter_if.sv
// AXIS bundle carrying LANES parallel streams (tdata lane n at [(n+1)*AXIS_BYTES*8-1 -: AXIS_BYTES*8]).
// master drives data/valid/last and receives ready; slave is the opposite side.
interface axis_packet_arbiter_if #(
    parameter int LANES      = 1,
    parameter int AXIS_BYTES = 1
);
    logic [LANES*AXIS_BYTES*8-1:0] tdata;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tlast;
    logic [LANES-1:0]              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS sink between NUM_INPUTS sources.
// Optional macro AXIS_ARB_BACK2BACK_EN: re-arbitrate on the packet-end beat instead of idling one cycle.
module axis_packet_arbiter #(
    parameter int NUM_INPUTS = 2,
    parameter int AXIS_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   sresetn,
    axis_packet_arbiter_if.slave   axis_i,
    axis_packet_arbiter_if.master  axis_o,
    output logic [NUM_INPUTS-1:0]  grant,
    output logic                   busy
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic          pkt_end;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] win_idx;

    // Wraps at NUM_INPUTS-1 so a non-power-of-two count never produces an out-of-range index.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (int'(i) >= NUM_INPUTS - 1)
            return '0;
        return i + PW'(1);
    endfunction

    function automatic logic [PW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                              input logic [PW-1:0]         start);
        logic [PW-1:0] idx;
        logic [PW-1:0] win;
        logic          found;
        idx   = start;
        win   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

    function automatic logic [NUM_INPUTS-1:0] onehot(input logic [PW-1:0] idx);
        logic [NUM_INPUTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    assign next_ptr = next_idx(gidx);
    assign win_idx  = rr_pick(axis_i.tvalid, (state == PASS) ? next_ptr : ptr);

    always_comb begin
        sel_valid = axis_i.tvalid[gidx];
        sel_last  = axis_i.tlast[gidx];
        sel_data  = axis_i.tdata[int'(gidx)*DW +: DW];

        axis_o.tvalid = 1'b0;
        axis_o.tlast  = 1'b0;
        axis_o.tdata  = '0;
        axis_i.tready = '0;
        if (state == PASS) begin
            axis_o.tvalid       = sel_valid;
            axis_o.tlast        = sel_last;
            axis_o.tdata        = sel_data;
            axis_i.tready[gidx] = axis_o.tready;
        end
    end

    assign pkt_end = (state == PASS) && sel_valid && sel_last && axis_o.tready;

    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            gidx  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|axis_i.tvalid) begin
                        gidx  <= win_idx;
                        grant <= onehot(win_idx);
                        state <= PASS;
                        busy  <= 1'b1;
                    end
                end
                PASS: begin
                    if (pkt_end) begin
                        ptr <= next_ptr;
`ifdef AXIS_ARB_BACK2BACK_EN
                        // win_idx already scans from the advanced pointer here.
                        if (|axis_i.tvalid) begin
                            gidx  <= win_idx;
                            grant <= onehot(win_idx);
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter (NUM_INPUTS=3): directed scenarios plus random traffic
// checked every cycle against a round-robin packet model.
`timescale 1ns/1ps
module tb_axis_packet_arbiter;
    localparam int N = 3;
    localparam int B = 1;
`ifdef AXIS_ARB_BACK2BACK_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    typedef struct { logic [7:0] d; logic l; } beat_t;
    typedef struct { logic [N-1:0] g; logic [7:0] d; logic l; int cyc; } obs_t;

    logic           clk = 1'b0;
    logic           sresetn = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [N-1:0]   tv = '0;
    logic [N-1:0]   tl = '0;
    logic [N*8-1:0] tdat = '0;
    logic           o_ready = 1'b0;

    axis_packet_arbiter_if #(.LANES(N), .AXIS_BYTES(B)) in_bus ();
    axis_packet_arbiter_if #(.LANES(1), .AXIS_BYTES(B)) out_bus ();

    assign in_bus.tvalid  = tv;
    assign in_bus.tlast   = tl;
    assign in_bus.tdata   = tdat;
    assign out_bus.tready = o_ready;

    axis_packet_arbiter #(.NUM_INPUTS(N), .AXIS_BYTES(B)) dut (
        .clk(clk), .sresetn(sresetn), .axis_i(in_bus), .axis_o(out_bus),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    beat_t srcq [N][$];
    obs_t  olog [$];
    bit    rdy_q [$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    mg = -1;
    int    mptr = 0;
    int    gate_pct = 100;
    int    rdy_pct = 100;

    function automatic int first_from(input logic [N-1:0] req, input int start);
        for (int i = 0; i < N; i++)
            if (req[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    function automatic bit pending();
        for (int n = 0; n < N; n++)
            if (srcq[n].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(input int n, input int len, input logic [7:0] base, input bit inc);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = inc ? 8'(base + i) : base;
            b.l = (i == len - 1);
            srcq[n].push_back(b);
        end
    endtask

    task automatic drive(input logic [N-1:0] popped);
        for (int n = 0; n < N; n++) begin
            if (popped[n] || !tv[n])
                tv[n] = (srcq[n].size() > 0) && (int'($urandom_range(99)) < gate_pct);
            if (tv[n]) begin
                tdat[n*8 +: 8] = srcq[n][0].d;
                tl[n]          = srcq[n][0].l;
            end else begin
                tdat[n*8 +: 8] = 8'($urandom);
                tl[n]          = 1'($urandom);
            end
        end
        if (rdy_q.size() > 0) o_ready = rdy_q.pop_front();
        else o_ready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    // One clock: check DUT against the model at the falling edge, then advance sources and model.
    task automatic step();
        logic [N-1:0] popped, exp_g, exp_r;
        logic         exp_v, exp_l, exp_b;
        logic [7:0]   exp_d;
        @(negedge clk);
        exp_g = '0; exp_r = '0; exp_v = 1'b0; exp_l = 1'b0; exp_d = '0;
        exp_b = (mg >= 0);
        if (mg >= 0) begin
            exp_g[mg] = 1'b1;
            exp_r[mg] = o_ready;
            exp_v     = tv[mg];
            exp_l     = tl[mg];
            exp_d     = tdat[mg*8 +: 8];
        end
        checks++; if (grant !== exp_g) begin errors++; $display("FAIL grant cyc=%0d: got %b expected %b", cyc, grant, exp_g); end
        checks++; if (busy !== exp_b) begin errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, exp_b); end
        checks++; if (out_bus.tvalid !== exp_v) begin errors++; $display("FAIL o_tvalid cyc=%0d: got %b expected %b", cyc, out_bus.tvalid, exp_v); end
        checks++; if (out_bus.tlast !== exp_l) begin errors++; $display("FAIL o_tlast cyc=%0d: got %b expected %b", cyc, out_bus.tlast, exp_l); end
        checks++; if (in_bus.tready !== exp_r) begin errors++; $display("FAIL i_tready cyc=%0d: got %b expected %b", cyc, in_bus.tready, exp_r); end
        if (exp_v) begin
            checks++; if (out_bus.tdata !== exp_d) begin errors++; $display("FAIL o_tdata cyc=%0d: got %h expected %h", cyc, out_bus.tdata, exp_d); end
        end
        if (out_bus.tvalid && o_ready) olog.push_back('{grant, out_bus.tdata, out_bus.tlast, cyc});
        popped = tv & in_bus.tready;
        for (int n = 0; n < N; n++)
            if (popped[n] && srcq[n].size() > 0) void'(srcq[n].pop_front());
        if (mg < 0) begin
            mg = first_from(tv, mptr);
        end else if (tv[mg] && tl[mg] && o_ready) begin
            mptr = (mg + 1) % N;
`ifdef AXIS_ARB_BACK2BACK_EN
            mg = first_from(tv, mptr);
`else
            mg = -1;
`endif
        end
        @(posedge clk); #1;
        cyc++;
        drive(popped);
    endtask

    task automatic do_reset();
        sresetn = 1'b0;
        for (int n = 0; n < N; n++) srcq[n].delete();
        tv = '0; tl = '0; rdy_q.delete(); olog.delete();
        mg = -1; mptr = 0; gate_pct = 100; rdy_pct = 100;
        repeat (2) @(posedge clk);
        @(negedge clk); sresetn = 1'b1;
        @(posedge clk); #1;
        cyc++;
        drive('0);
    endtask

    task automatic drain(input int max_cycles, input string name);
        int k = 0;
        while (pending() && k < max_cycles) begin step(); k++; end
        repeat (2) step();
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s drain: beats still queued after %0d cycles, expected none", name, max_cycles);
        end
    endtask

    task automatic test_reset();
        sresetn = 1'b0; tv = '1; tl = '1; tdat = 24'hA5A5A5; o_ready = 1'b1;
        @(negedge clk);
        checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b expected 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (out_bus.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b expected 0", out_bus.tvalid); end
        checks++; if (out_bus.tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b expected 0", out_bus.tlast); end
        checks++; if (out_bus.tdata !== 8'h00) begin errors++; $display("FAIL rst_tdata: got %h expected 00", out_bus.tdata); end
        checks++; if (in_bus.tready !== '0) begin errors++; $display("FAIL rst_tready: got %b expected 000", in_bus.tready); end
        do_reset();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        add_pkt(1, 1, 8'h30, 1'b1);
        drain(20, "mid_pre");
        add_pkt(0, 4, 8'h40, 1'b1);
        repeat (3) step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL mid_grant_before: got %b expected 001", grant); end
        sresetn = 1'b0;
        #2;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_rst_grant: got %b expected 000", grant); end
        checks++; if (out_bus.tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b expected 0", out_bus.tvalid); end
        checks++; if (in_bus.tready !== 3'b000) begin errors++; $display("FAIL mid_rst_tready: got %b expected 000", in_bus.tready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        do_reset();
        add_pkt(1, 1, 8'h31, 1'b1);
        add_pkt(2, 1, 8'h32, 1'b1);
        drain(20, "mid_post");
        checks++;
        if (olog.size() != 2 || olog[0].g !== 3'b010 || olog[0].d !== 8'h31) begin
            errors++;
            $display("FAIL mid_rearb: got %0d beats first grant %b data %h, expected 2 beats first grant 010 data 31",
                     olog.size(), olog[0].g, olog[0].d);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        int src;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int n = 0; n < N; n++) add_pkt(n, 2, 8'hA0 | 8'(n), 1'b0);
        drain(100, "rr");
        checks++; if (olog.size() != 12) begin errors++; $display("FAIL rr_count: got %0d beats expected 12", olog.size()); end
        for (int k = 0; k < 12; k++) begin
            src = (k / 2) % N;
            eg = '0; eg[src] = 1'b1;
            checks++;
            if (olog[k].g !== eg || olog[k].d !== (8'hA0 | 8'(src)) || olog[k].l !== 1'(k % 2)) begin
                errors++;
                $display("FAIL rr_beat%0d: got grant %b data %h last %b, expected grant %b data %h last %0d",
                         k, olog[k].g, olog[k].d, olog[k].l, eg, 8'hA0 | 8'(src), k % 2);
            end
            if (k % 2 == 0 && k > 0) begin
                checks++;
                if (olog[k].cyc - olog[k-1].cyc != GAP) begin
                    errors++;
                    $display("FAIL rr_gap%0d: got %0d cycles between packets expected %0d", k, olog[k].cyc - olog[k-1].cyc, GAP);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(1, 3, 8'h50, 1'b1);
        for (int i = 0; i < 12; i++) rdy_q.push_back(1'(i % 2 == 0));
        drain(30, "bp");
        checks++; if (olog.size() != 3) begin errors++; $display("FAIL bp_count: got %0d beats expected 3", olog.size()); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (olog[k].d !== 8'(8'h50 + k) || olog[k].l !== (k == 2) || olog[k].g !== 3'b010) begin
                errors++;
                $display("FAIL bp_beat%0d: got data %h last %b grant %b, expected data %h last %0d grant 010",
                         k, olog[k].d, olog[k].l, olog[k].g, 8'(8'h50 + k), k == 2);
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int i = 0; i < 5; i++) add_pkt(2, 1, 8'(8'h11 + i), 1'b1);
        drain(40, "single");
        checks++; if (olog.size() != 5) begin errors++; $display("FAIL single_count: got %0d beats expected 5", olog.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (olog[k].d !== 8'(8'h11 + k) || olog[k].l !== 1'b1 || olog[k].g !== 3'b100) begin
                errors++;
                $display("FAIL single_beat%0d: got data %h last %b grant %b, expected data %h last 1 grant 100",
                         k, olog[k].d, olog[k].l, olog[k].g, 8'(8'h11 + k));
            end
        end
    endtask

    task automatic test_late_requester();
        do_reset();
        add_pkt(0, 4, 8'h60, 1'b1);
        repeat (3) step();
        add_pkt(1, 2, 8'h70, 1'b1);
        drain(40, "late");
        checks++; if (olog.size() != 6) begin errors++; $display("FAIL late_count: got %0d beats expected 6", olog.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (olog[k].g !== ((k < 4) ? 3'b001 : 3'b010) || olog[k].d !== ((k < 4) ? 8'(8'h60 + k) : 8'(8'h70 + k - 4))) begin
                errors++;
                $display("FAIL late_beat%0d: got grant %b data %h, expected grant %b", k, olog[k].g, olog[k].d,
                         (k < 4) ? 3'b001 : 3'b010);
            end
        end
        checks++;
        if (olog[4].cyc - olog[3].cyc != GAP) begin
            errors++;
            $display("FAIL late_gap: got %0d cycles expected %0d", olog[4].cyc - olog[3].cyc, GAP);
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        add_pkt(2, 1, 8'h21, 1'b1);
        drain(20, "wrap_pre");
        add_pkt(0, 1, 8'h01, 1'b1);
        add_pkt(2, 1, 8'h22, 1'b1);
        drain(20, "wrap");
        checks++;
        if (olog.size() != 3 || olog[1].g !== 3'b001 || olog[1].d !== 8'h01 || olog[2].g !== 3'b100) begin
            errors++;
            $display("FAIL wrap_order: got %0d beats, grants %b then %b, expected 3 beats, 001 then 100",
                     olog.size(), olog[1].g, olog[2].g);
        end
    endtask

    task automatic test_random();
        do_reset();
        gate_pct = 60;
        rdy_pct  = 70;
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < N; n++)
                if (srcq[n].size() < 3) add_pkt(n, 1 + int'($urandom_range(3)), 8'($urandom), 1'b1);
            step();
        end
        checks++;
        if (olog.size() < 50) begin errors++; $display("FAIL random_throughput: got %0d beats expected at least 50", olog.size()); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_packet();
        test_round_robin();
        test_backpressure();
        test_single_beat();
        test_late_requester();
        test_ptr_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1);
    end
endmodule
